// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer shared types and constants.
// Op encoding matches the 1-bit shifter control.
package shift_seq_pkg;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  typedef enum logic [1:0] {
    SH_PASS = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_t;

  typedef enum {IDLE, SHIFT, DONE} seq_state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for shift_sequencer.
// master = requester/consumer side, slave = sequencer.
interface shift_sequencer_if;
  import shift_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             flush;

  modport master (
    output in_valid, in_data, in_op, in_amt,
    output out_ready, flush,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_op, in_amt,
    input  out_ready, flush,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/shift_sequencer_shifter.sv
// Single-bit shifter datapath: one LSL/LSR/ASR step
// per use, or pass-through for control 00.
module shifter
  import shift_seq_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  output logic [WIDTH-1:0] sout
);

  // One-step shift; ASR replicates the sign bit.
  always_comb begin
    sout = in;
    case (shift)
      SH_LSL:  sout = {in[WIDTH-2:0], 1'b0};
      SH_LSR:  sout = {1'b0, in[WIDTH-1:1]};
      SH_ASR:  sout = {in[WIDTH-1], in[WIDTH-1:1]};
      default: sout = in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: iterates the 1-bit
// shifter once per clock over an accumulator.
module shift_sequencer
  import shift_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  shift_sequencer_if.slave    io
);

  seq_state_t       state;
  logic [WIDTH-1:0] acc;
  logic [AMT_W-1:0] cnt;
  shift_op_t        op_q;
  shift_op_t        sh_ctl;
  logic [WIDTH-1:0] sh_out;
  logic             in_rdy_q;
  logic             out_vld_q;
  logic             busy_q;

  assign sh_ctl = (state == SHIFT) ? op_q : SH_PASS;

  shifter u_shifter (
    .in    (acc),
    .shift (sh_ctl),
    .sout  (sh_out)
  );

  assign io.in_ready  = in_rdy_q;
  assign io.out_valid = out_vld_q;
  assign io.out_data  = acc;
  assign io.busy      = busy_q;

  // Sequencer FSM with accumulator, counter and
  // registered handshake outputs; flush wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      op_q      <= SH_PASS;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (io.flush) begin
      state     <= IDLE;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            acc      <= io.in_data;
            op_q     <= shift_op_t'(io.in_op);
            cnt      <= io.in_amt;
            in_rdy_q <= 1'b0;
            busy_q   <= 1'b1;
            if (io.in_amt == '0 ||
                io.in_op == SH_PASS) begin
              state     <= DONE;
              out_vld_q <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc <= sh_out;
          cnt <= cnt - 1'b1;
          if (cnt == AMT_W'(1)) begin
            state     <= DONE;
            out_vld_q <= 1'b1;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            state     <= IDLE;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            in_rdy_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with
// hand-computed results and latencies.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_err;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag,
                     input logic [1:0] op,
                     input logic [3:0] amt,
                     input logic [15:0] d,
                     input logic [15:0] exp,
                     input int lat);
    int n;
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_amt   = amt;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h5A5A;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_vld0"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_op     = '0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    step();
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    step();

    run("lsl3", 2'b01, 4'd3, 16'h0013, 16'h0098, 3);
    run("asr15", 2'b11, 4'd15, 16'h8000, 16'hFFFF, 15);
    run("lsr15", 2'b10, 4'd15, 16'h8000, 16'h0001, 15);
    run("amt0", 2'b01, 4'd0, 16'hABCD, 16'hABCD, 0);
    run("pass7", 2'b00, 4'd7, 16'hABCD, 16'hABCD, 0);
    run("lslff", 2'b01, 4'd15, 16'hFFFF, 16'h8000, 15);
    run("asr4", 2'b11, 4'd4, 16'h7F00, 16'h07F0, 4);
    run("lsr4", 2'b10, 4'd4, 16'hF00F, 16'h0F00, 4);

    // Backpressure with a pending second request.
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b10;
    bus.in_amt   = 4'd2;
    bus.in_data  = 16'h00F0;
    step();
    bus.in_op    = 2'b01;
    bus.in_amt   = 4'd1;
    bus.in_data  = 16'h1234;
    step();
    step();
    chk("bp_vld", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", 32'(bus.out_data), 32'h003C);
      chk("bp_rdy", 32'(bus.in_ready), 32'd0);
      chk("bp_vldh", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_hs_rdy", 32'(bus.in_ready), 32'd1);
    chk("bp_hs_vld", 32'(bus.out_valid), 32'd0);
    step();
    bus.in_valid = 1'b0;
    chk("bp2_busy", 32'(bus.busy), 32'd1);
    chk("bp2_vld0", 32'(bus.out_valid), 32'd0);
    step();
    chk("bp2_vld", 32'(bus.out_valid), 32'd1);
    chk("bp2_data", 32'(bus.out_data), 32'h2468);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Flush two steps into a 10-step shift.
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b01;
    bus.in_amt   = 4'd10;
    bus.in_data  = 16'h0001;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("fl_busy", 32'(bus.busy), 32'd1);
    chk("fl_acc", 32'(bus.out_data), 32'h0004);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7777;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_rdy", 32'(bus.in_ready), 32'd1);
    chk("fl_busy0", 32'(bus.busy), 32'd0);
    chk("fl_vld", 32'(bus.out_valid), 32'd0);
    chk("fl_keep", 32'(bus.out_data), 32'h0004);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("fl_novld", 32'(bus.out_valid), 32'd0);
    end
    run("postfl", 2'b01, 4'd1, 16'h0003, 16'h0006, 1);

    // Reset asserted mid-shift.
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b01;
    bus.in_amt   = 4'd10;
    bus.in_data  = 16'h0101;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("mr_rdy", 32'(bus.in_ready), 32'd1);
    chk("mr_vld", 32'(bus.out_valid), 32'd0);
    chk("mr_data", 32'(bus.out_data), 32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    run("postrst", 2'b10, 4'd3, 16'h0080, 16'h0010, 3);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
